// File: rtl/banco_registros_hora_rtc.sv
// rtl/banco_registros_hora_rtc.sv - RTC time/date shadow registers with BCD-checked atomic commit to display
module banco_registros_hora_rtc #(
    parameter logic [7:0] BASE_ADDR = 8'h20,
    parameter logic [7:0] YEAR_MAX  = 8'h99
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_port_id,
    input  logic [7:0] i_out_port,
    input  logic       i_write_strobe,
    input  logic       i_read_strobe,
    output logic [7:0] o_dato_lectura,
    output logic [7:0] o_seg,
    output logic [7:0] o_min,
    output logic [7:0] o_hora,
    output logic [7:0] o_dia,
    output logic [7:0] o_mes,
    output logic [7:0] o_anio,
    output logic       o_actualizado,
    output logic       o_error_bcd
);

    typedef enum logic {S_IDLE, S_CHECK} state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_sh   [6];
    logic [7:0] r_snap [6];
    logic [7:0] r_disp [6];
    logic [7:0] r_dato;
    logic       r_actualizado, r_error, r_overrun, r_nuevo;

    logic       w_in_window, w_hit, w_cmd, w_commit, w_clr, w_valid, w_apply, w_status_rd;
    logic [2:0] w_off;
    logic [7:0] w_rd_byte;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        // With both nibbles <= 9, plain byte comparison orders BCD values correctly.
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    assign w_in_window = (i_port_id[7:3] == BASE_ADDR[7:3]);
    assign w_off       = i_port_id[2:0];
    assign w_hit       = i_write_strobe && w_in_window;
    assign w_cmd       = w_hit && (w_off == 3'd6);
    assign w_commit    = w_cmd && i_out_port[0];
    assign w_clr       = w_cmd && i_out_port[1];
    assign w_status_rd = i_read_strobe && (i_port_id == (BASE_ADDR | 8'h07));

    assign w_valid = bcd_ok(r_snap[0], 8'h00, 8'h59) && bcd_ok(r_snap[1], 8'h00, 8'h59) &&
                     bcd_ok(r_snap[2], 8'h00, 8'h23) && bcd_ok(r_snap[3], 8'h01, 8'h31) &&
                     bcd_ok(r_snap[4], 8'h01, 8'h12) && bcd_ok(r_snap[5], 8'h00, YEAR_MAX);
    assign w_apply = (r_state == S_CHECK) && w_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_commit) w_state_next = S_CHECK;
            S_CHECK: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_byte = 8'h00;
        if (w_in_window) begin
            case (w_off)
                3'd0: w_rd_byte = r_sh[0];
                3'd1: w_rd_byte = r_sh[1];
                3'd2: w_rd_byte = r_sh[2];
                3'd3: w_rd_byte = r_sh[3];
                3'd4: w_rd_byte = r_sh[4];
                3'd5: w_rd_byte = r_sh[5];
                3'd7: w_rd_byte = {4'b0, r_overrun, r_nuevo, r_error, (r_state == S_CHECK)};
                default: w_rd_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_sh          <= '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
            r_snap        <= '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
            r_disp        <= '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
            r_dato        <= 8'h00;
            r_actualizado <= 1'b0;
            r_error       <= 1'b0;
            r_overrun     <= 1'b0;
            r_nuevo       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_dato        <= w_rd_byte;
            r_actualizado <= w_apply;
            if (w_hit) begin
                case (w_off)
                    3'd0: r_sh[0] <= i_out_port;
                    3'd1: r_sh[1] <= i_out_port;
                    3'd2: r_sh[2] <= i_out_port;
                    3'd3: r_sh[3] <= i_out_port;
                    3'd4: r_sh[4] <= i_out_port;
                    3'd5: r_sh[5] <= i_out_port;
                    default: ;
                endcase
            end
            if (r_state == S_IDLE && w_commit) r_snap <= r_sh;
            if (w_apply) r_disp <= r_snap;
            // The commit verdict overrides a clear issued on the same edge.
            if (r_state == S_CHECK)  r_error <= !w_valid;
            else if (w_clr)          r_error <= 1'b0;
            if (r_state == S_CHECK && w_commit) r_overrun <= 1'b1;
            else if (w_clr)                      r_overrun <= 1'b0;
            if (w_apply)          r_nuevo <= 1'b1;
            else if (w_status_rd) r_nuevo <= 1'b0;
        end
    end

    assign o_dato_lectura = r_dato;
    assign o_seg          = r_disp[0];
    assign o_min          = r_disp[1];
    assign o_hora         = r_disp[2];
    assign o_dia          = r_disp[3];
    assign o_mes          = r_disp[4];
    assign o_anio         = r_disp[5];
    assign o_actualizado  = r_actualizado;
    assign o_error_bcd    = r_error;

endmodule

// File: tb/tb_banco_registros_hora_rtc.sv
// tb/tb_banco_registros_hora_rtc.sv - scoreboard bench with reference model for banco_registros_hora_rtc
module tb_banco_registros_hora_rtc;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_port_id = 8'h00;
    logic [7:0] i_out_port = 8'h00;
    logic       i_write_strobe = 1'b0;
    logic       i_read_strobe = 1'b0;
    logic [7:0] o_dato_lectura, o_seg, o_min, o_hora, o_dia, o_mes, o_anio;
    logic       o_actualizado, o_error_bcd;

    always #5 clk = ~clk;

    banco_registros_hora_rtc dut (
        .i_clk(clk), .i_reset(i_reset), .i_port_id(i_port_id), .i_out_port(i_out_port),
        .i_write_strobe(i_write_strobe), .i_read_strobe(i_read_strobe),
        .o_dato_lectura(o_dato_lectura), .o_seg(o_seg), .o_min(o_min), .o_hora(o_hora),
        .o_dia(o_dia), .o_mes(o_mes), .o_anio(o_anio),
        .o_actualizado(o_actualizado), .o_error_bcd(o_error_bcd)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: fields indexed 0..5 = seg,min,hora,dia,mes,anio
    logic [7:0]  m_sh [6];
    logic [7:0]  m_snap [6];
    logic [7:0]  m_disp [6];
    bit          m_err, m_ovr, m_nuevo, m_pend;
    logic [7:0]  rdq [$];
    logic [47:0] apq [$];
    logic        rd_d = 1'b0;
    logic [7:0]  exp_rd;
    logic [47:0] exp_ap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] b);
        if (b[7:4] > 9 || b[3:0] > 9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit in_range(input logic [7:0] b, input int lo, input int hi);
        int v;
        v = bcd2int(b);
        return (v >= 0) && (v >= lo) && (v <= hi);
    endfunction

    function automatic bit snap_valid();
        return in_range(m_snap[0], 0, 59) && in_range(m_snap[1], 0, 59) && in_range(m_snap[2], 0, 23) &&
               in_range(m_snap[3], 1, 31) && in_range(m_snap[4], 1, 12) && in_range(m_snap[5], 0, 99);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] pid);
        int off;
        if (pid < 8'h20 || pid > 8'h27) return 8'h00;
        off = int'(pid) - 32;
        if (off < 6) return m_sh[off];
        if (off == 6) return 8'h00;
        return {4'b0, m_ovr, m_nuevo, m_err, m_pend};
    endfunction

    task automatic model_reset();
        m_sh   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
        m_snap = m_sh;
        m_disp = m_sh;
        m_err = 0; m_ovr = 0; m_nuevo = 0; m_pend = 0;
    endtask

    task automatic model_edge(input bit we, input bit rd, input logic [7:0] pid, input logic [7:0] data);
        bit hit, com, clr, applied;
        int off;
        hit = we && pid >= 8'h20 && pid <= 8'h27;
        off = int'(pid) - 32;
        com = hit && off == 6 && data[0];
        clr = hit && off == 6 && data[1];
        applied = 0;
        if (hit && off < 6) m_sh[off] = data;
        if (clr) begin m_err = 0; m_ovr = 0; end
        if (m_pend) begin
            if (snap_valid()) begin
                m_disp = m_snap;
                apq.push_back({m_disp[0], m_disp[1], m_disp[2], m_disp[3], m_disp[4], m_disp[5]});
                m_err = 0; m_nuevo = 1; applied = 1;
            end else begin
                m_err = 1;
            end
            if (com) m_ovr = 1;
            m_pend = 0;
        end else if (com) begin
            m_snap = m_sh;
            m_pend = 1;
        end
        if (rd && pid == 8'h27 && !applied) m_nuevo = 0;
    endtask

    task automatic cyc(input bit rst, input bit we, input bit rd, input logic [7:0] pid, input logic [7:0] data);
        i_reset = rst; i_write_strobe = we; i_read_strobe = rd; i_port_id = pid; i_out_port = data;
        if (rst) model_reset();
        else begin
            if (rd) rdq.push_back(model_read(pid));
            model_edge(we, rd, pid, data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] pid, input logic [7:0] data); cyc(0, 1, 0, pid, data); endtask
    task automatic rd(input logic [7:0] pid); cyc(0, 0, 1, pid, 8'h00); endtask
    task automatic idle(); cyc(0, 0, 0, 8'h00, 8'h00); endtask

    task automatic chk_state(input string name);
        chk({name, "_disp"}, {o_seg, o_min, o_hora, o_dia, o_mes, o_anio},
            {m_disp[0], m_disp[1], m_disp[2], m_disp[3], m_disp[4], m_disp[5]});
        chk({name, "_err"}, o_error_bcd, m_err);
    endtask

    always @(posedge clk) rd_d <= i_read_strobe && !i_reset;

    always @(negedge clk) begin
        if (rd_d) begin
            if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                exp_rd = rdq.pop_front();
                chk("dato_lectura", o_dato_lectura, exp_rd);
            end
        end
        if (o_actualizado === 1'b1) begin
            if (apq.size() == 0) chk("actualizado_unexpected", 1, 0);
            else begin
                exp_ap = apq.pop_front();
                chk("apply_disp", {o_seg, o_min, o_hora, o_dia, o_mes, o_anio}, exp_ap);
            end
        end
    end

    logic [7:0] vals [6];

    initial begin
        int r, off;
        logic [7:0] d;
        vals = '{8'h45, 8'h59, 8'h23, 8'h31, 8'h12, 8'h16};
        model_reset();
        cyc(1, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 0, 8'h00, 8'h00);
        chk_state("reset");
        chk("reset_act", o_actualizado, 0);
        chk("reset_dato", o_dato_lectura, 8'h00);
        for (int p = 8'h1F; p <= 8'h27; p++) rd(8'(p));

        for (int k = 0; k < 6; k++) wr(8'(32 + k), vals[k]);
        wr(8'h26, 8'h01);
        rd(8'h27);
        rd(8'h27);
        rd(8'h27);
        chk_state("t2");
        chk("t2_const", {o_seg, o_min, o_hora, o_dia, o_mes, o_anio}, 48'h455923311216);

        wr(8'h22, 8'h24); wr(8'h26, 8'h01); idle();
        chk_state("t3_rej");
        chk("t3_err_const", o_error_bcd, 1);
        wr(8'h26, 8'h02);
        chk("t3_clr_const", o_error_bcd, 0);
        wr(8'h22, 8'h23);

        wr(8'h20, 8'h3A); wr(8'h26, 8'h01); idle();
        chk_state("t4_rej");
        wr(8'h20, 8'h30); wr(8'h26, 8'h01); idle();
        chk_state("t4_ok");
        chk("t4_const", {o_seg, o_min, o_hora, o_dia, o_mes, o_anio}, 48'h305923311216);

        wr(8'h20, 8'h10); wr(8'h26, 8'h01); wr(8'h26, 8'h01); idle();
        wr(8'h26, 8'h01); wr(8'h20, 8'h55); idle();
        chk("t5_seg_const", o_seg, 8'h10);
        rd(8'h27);
        idle();
        chk_state("t5");

        wr(8'h21, 8'h07); rd(8'h21); rd(8'h1F); rd(8'h26); idle();
        wr(8'h20, 8'h12); wr(8'h26, 8'h01);
        cyc(1, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 0, 8'h00, 8'h00);
        idle(); idle();
        chk("t6_rst_const", {o_seg, o_min, o_hora, o_dia, o_mes, o_anio, o_actualizado}, {48'h000000010100, 1'b0});

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 199);
            if (r < 80) begin
                off = $urandom_range(0, 5);
                case (off)
                    0, 1: d = to_bcd($urandom_range(0, 59));
                    2:    d = to_bcd($urandom_range(0, 23));
                    3:    d = to_bcd($urandom_range(1, 31));
                    4:    d = to_bcd($urandom_range(1, 12));
                    default: d = to_bcd($urandom_range(0, 99));
                endcase
                if ($urandom_range(0, 4) == 0) d = 8'($urandom);
                wr(8'(32 + off), d);
            end else if (r < 110) wr(8'h26, 8'($urandom_range(1, 3)));
            else if (r < 170)     rd(8'($urandom_range(8'h1C, 8'h2B)));
            else if (r < 199)     idle();
            else                  cyc(1, 0, 0, 8'h00, 8'h00);
            chk_state("rand");
        end
        idle(); idle(); idle();
        chk("apq_drained", apq.size(), 0);
        chk("rdq_drained", rdq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
